multitap_delay_scale: RTL and testbench
=======================================

# multitap_delay_scale

Parametrised successor to the single-tap delay-and-scale stage in the anti-noise path. Keeps a circular history of the last DEPTH input samples and, once per input sample, forms the sum of TAPS delayed copies, each with its own runtime delay and signed fractional gain. The saturated sum is presented with a one-cycle done pulse. It sits between the mic-sample front end (ready-strobed, one sample per ~128 clocks) and the anti-noise output mixer.

## Interface
- DATA_W, 16, signed sample width
- DEPTH, 256, history length; power of two; ADDR_W = $clog2(DEPTH)
- TAPS, 4, number of taps, 1..16
- SCALE_W, 8, per-tap gain width, signed Q1.(SCALE_W-1)

- clk_in  in  1  sole clock
- reset_in  in  1  asynchronous, active-high reset
- ready_in  in  1  single-cycle strobe: signal_in valid
- signal_in  in  DATA_W  signed input sample
- delay_in  in  TAPS*ADDR_W  packed per-tap delay in samples; tap i at [i*ADDR_W +: ADDR_W]
- scale_in  in  TAPS*SCALE_W  packed per-tap signed gain; tap i at [i*SCALE_W +: SCALE_W]
- signal_out  out  DATA_W  saturated weighted sum; held until next result
- done_out  out  1  one-cycle pulse: signal_out updated
- busy_out  out  1  high from accept until done_out inclusive
- overrun_out  out  1  one-cycle pulse: ready_in dropped while busy

## Operation
- States: IDLE, ACCUM, FINISH.
- IDLE + ready_in: write signal_in to mem[wptr], snapshot delay_in and scale_in, clear accumulator, fill = min(fill+1, DEPTH), go ACCUM.
- ACCUM: issue one synchronous-read address per cycle, tap i: (wptr − delay_i) mod DEPTH. Delay 0 returns the just-written sample. MAC runs one cycle behind the read. After the last address issues, wptr increments (mod DEPTH). Go FINISH.
- FINISH: absorb the final product, shift, saturate, register signal_out, pulse done_out, return to IDLE.
- Fill gating: a tap with delay_i ≥ fill contributes 0. The RAM is never cleared.
- Arithmetic:
  - Product: DATA_W+SCALE_W signed.
  - Accumulator: DATA_W+SCALE_W+$clog2(TAPS)+1 signed.
  - Result: acc >>> (SCALE_W-1), then saturate to [−2^(DATA_W-1), 2^(DATA_W-1)−1].
- ready_in outside IDLE: sample discarded, wptr/fill unchanged, overrun_out pulses. The in-flight computation is unaffected.
- Changes to delay_in/scale_in during ACCUM have no effect on the current sample.
- Reset (any time, including mid-ACCUM):
  - State IDLE; wptr=0; fill=0; accumulator=0.
  - Outputs: signal_out=0, done_out=0, busy_out=0, overrun_out=0.
  - No done_out for the aborted sample.

## Timing
- Edge E0 samples ready_in=1. Read addresses issue at E1..E_TAPS.
- The last MAC occurs at E_(TAPS+1). signal_out/done_out update at E_(TAPS+2), so latency is TAPS+2 clocks.
- busy_out is high from E0 through the cycle of done_out.
- A new ready_in is accepted on the edge after done_out. Minimum sample spacing is TAPS+3 clocks.
- ready_in on the same edge done_out drops is accepted.

## Configuration
- MULTITAP_DELAY_SCALE_ROUND_EN defined: add 2^(SCALE_W-2) to the accumulator before the arithmetic shift (round half up).
- Not defined: plain truncation toward −∞.

## Test plan
All scenarios use defaults (DATA_W=16, DEPTH=256, TAPS=4, SCALE_W=8).
- Impulse:
  - Stimulus: tap0 delay=10, scale=0x40; other scales 0; input 1000 then zeros.
  - Response: output index 10 = 500, all others 0.
  - Rounding check: input 3 gives 2 with ROUND_EN, 1 without.
- Saturation:
  - Stimulus: taps 0,1 delay=0, scale=0x80; input −32768.
  - Response: 32767.
  - Stimulus: scale=0x7F, input 32767.
  - Response: 32767 (not wrapped).
- Fill gating:
  - Stimulus: after reset, tap0 delay=5, scale=0x7F; constant input 128.
  - Response: first 5 outputs 0, then 127.
- Wrap-around:
  - Stimulus: ramp 0..599, tap0 delay=255, scale=0x40.
  - Response: output n = (n−255)>>1 for n ≥ 255, including across wptr wrap at 256 and 512.
- Overrun and latency:
  - Stimulus: ready_in at E0 and again at E0+2.
  - Response: overrun_out pulses at E0+2; done_out at E0+6; next output ignores the dropped sample.
- Mid-operation reset:
  - Stimulus: reset_in asserted at E0+2.
  - Response: all outputs 0 immediately, no done_out. The following sample behaves as the first after reset (fill gating applies).

Source files
------------

// File: rtl/multitap_delay_scale.sv
// ---------------------------------------------------------------------------
// multitap_delay_scale
//
// Multi-tap delay-and-scale stage for the anti-noise path. A circular
// history RAM holds the last DEPTH samples. For each accepted sample the
// block forms sum_i( x[n - delay_i] * scale_i ), shifts it down by
// SCALE_W-1, saturates it to DATA_W and presents it with a done pulse.
//
// Optional build macro: MULTITAP_DELAY_SCALE_ROUND_EN
//   defined     -> add half an LSB before the final shift (round half up)
//   not defined -> plain arithmetic-shift truncation toward -inf
//
// Ports
//   clk_in       sole clock
//   reset_in     asynchronous, active-high reset
//   ready_in     one-cycle strobe, signal_in valid
//   signal_in    signed input sample (DATA_W)
//   delay_in     packed per-tap delays, tap i at [i*ADDR_W +: ADDR_W]
//   scale_in     packed per-tap signed Q1.(SCALE_W-1) gains
//   signal_out   saturated weighted sum, held until the next result
//   done_out     one-cycle pulse, signal_out updated
//   busy_out     high from accept through the done_out cycle
//   overrun_out  one-cycle pulse, ready_in seen while not idle
// ---------------------------------------------------------------------------
module multitap_delay_scale #(
   parameter int DATA_W  = 16,
   parameter int DEPTH   = 256,
   parameter int TAPS    = 4,
   parameter int SCALE_W = 8,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic                      clk_in,
   input  logic                      reset_in,
   input  logic                      ready_in,
   input  logic [DATA_W-1:0]         signal_in,
   input  logic [TAPS*ADDR_W-1:0]    delay_in,
   input  logic [TAPS*SCALE_W-1:0]   scale_in,
   output logic [DATA_W-1:0]         signal_out,
   output logic                      done_out,
   output logic                      busy_out,
   output logic                      overrun_out
);

   localparam int TAP_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam int FILL_W = ADDR_W + 1;
   localparam int PROD_W = DATA_W + SCALE_W;
   localparam int ACC_W  = DATA_W + SCALE_W + $clog2(TAPS) + 1;

   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FINISH} state_t;

   state_t                    state_q, state_d;
   logic [ADDR_W-1:0]         wptr_q;
   logic [FILL_W-1:0]         fill_q;
   logic [TAPS*ADDR_W-1:0]    dly_q;
   logic [TAPS*SCALE_W-1:0]   scl_q;
   logic [TAP_W-1:0]          tap_q;     // tap whose address issues this cycle
   logic [TAP_W-1:0]          mtap_q;    // tap whose read data is in rdata_q
   logic                      mgate_q;   // that tap is inside the filled history
   logic                      mvld_q;    // rdata_q holds a product to absorb
   logic                      fin_q;     // FINISH phase: 0 = last MAC, 1 = output
   logic signed [ACC_W-1:0]   acc_q;
   logic [DATA_W-1:0]         sig_q;
   logic                      done_q;
   logic                      ovr_q;
   logic [DATA_W-1:0]         rdata_q;

   logic [DATA_W-1:0]         mem [DEPTH];

   logic                      accept;
   logic                      last_tap;
   logic [ADDR_W-1:0]         cur_dly;
   logic [ADDR_W-1:0]         rd_addr;
   logic [SCALE_W-1:0]        mscl;
   logic signed [PROD_W-1:0]  prod;
   logic signed [ACC_W-1:0]   acc_sum;
   logic signed [ACC_W-1:0]   acc_rnd;
   logic signed [ACC_W-1:0]   shifted;
   logic [DATA_W-1:0]         sat_val;

   assign accept   = (state_q == S_IDLE) && ready_in;
   assign last_tap = (tap_q == TAP_W'(TAPS-1));
   assign cur_dly  = dly_q[tap_q*ADDR_W +: ADDR_W];
   // ADDR_W-bit subtraction wraps, giving the circular (mod DEPTH) address.
   assign rd_addr  = wptr_q - cur_dly;
   assign mscl     = scl_q[mtap_q*SCALE_W +: SCALE_W];
   assign prod     = PROD_W'($signed(rdata_q)) * PROD_W'($signed(mscl));
   assign acc_sum  = (mvld_q && mgate_q) ? acc_q + ACC_W'(prod) : acc_q;

`ifdef MULTITAP_DELAY_SCALE_ROUND_EN
   localparam logic signed [ACC_W-1:0] ROUND_K = ACC_W'(1) << (SCALE_W-2);
   assign acc_rnd = acc_q + ROUND_K;
`else
   assign acc_rnd = acc_q;
`endif

   assign shifted = acc_rnd >>> (SCALE_W-1);

   always_comb begin
      sat_val = shifted[DATA_W-1:0];
      if (shifted > SAT_MAX)      sat_val = SAT_MAX[DATA_W-1:0];
      else if (shifted < SAT_MIN) sat_val = SAT_MIN[DATA_W-1:0];
   end

   // History RAM: write on accept, synchronous read while taps issue. A
   // delay-0 tap reads the sample written on the accept edge, one edge later.
   always_ff @(posedge clk_in) begin
      if (accept) mem[wptr_q] <= signal_in;
      if (state_q == S_ACCUM) rdata_q <= mem[rd_addr];
   end

   // FSM: state register
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (ready_in) state_d = S_ACCUM;
         S_ACCUM:  if (last_tap) state_d = S_FINISH;
         S_FINISH: if (fin_q)    state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // FSM: outputs. done_q covers the done cycle, when the FSM is already idle.
   always_comb begin
      busy_out    = (state_q != S_IDLE) || done_q;
      done_out    = done_q;
      overrun_out = ovr_q;
      signal_out  = sig_q;
   end

   // Datapath
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         wptr_q  <= '0;
         fill_q  <= '0;
         dly_q   <= '0;
         scl_q   <= '0;
         tap_q   <= '0;
         mtap_q  <= '0;
         mgate_q <= 1'b0;
         mvld_q  <= 1'b0;
         fin_q   <= 1'b0;
         acc_q   <= '0;
         sig_q   <= '0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         ovr_q  <= ready_in && (state_q != S_IDLE);
         case (state_q)
            S_IDLE: begin
               if (ready_in) begin
                  dly_q  <= delay_in;
                  scl_q  <= scale_in;
                  acc_q  <= '0;
                  tap_q  <= '0;
                  mvld_q <= 1'b0;
                  fin_q  <= 1'b0;
                  if (fill_q != FILL_W'(DEPTH)) fill_q <= fill_q + 1'b1;
               end
            end
            S_ACCUM: begin
               acc_q   <= acc_sum;
               mtap_q  <= tap_q;
               // Taps reaching past the samples written since reset read 0.
               mgate_q <= {1'b0, cur_dly} < fill_q;
               mvld_q  <= 1'b1;
               tap_q   <= tap_q + 1'b1;
               if (last_tap) begin
                  tap_q  <= '0;
                  wptr_q <= wptr_q + 1'b1;
               end
            end
            S_FINISH: begin
               if (!fin_q) begin
                  acc_q  <= acc_sum;
                  mvld_q <= 1'b0;
                  fin_q  <= 1'b1;
               end else begin
                  sig_q  <= sat_val;
                  done_q <= 1'b1;
                  fin_q  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multitap_delay_scale.sv
module tb_multitap_delay_scale;

   localparam int DW = 16;
   localparam int AW = 8;
   localparam int NT = 4;
   localparam int SW = 8;

   logic              clk_in = 1'b0;
   logic              reset_in;
   logic              ready_in;
   logic [DW-1:0]     signal_in;
   logic [NT*AW-1:0]  delay_in;
   logic [NT*SW-1:0]  scale_in;
   logic [DW-1:0]     signal_out;
   logic              done_out;
   logic              busy_out;
   logic              overrun_out;

   int n_vec = 0;
   int n_err = 0;
   int exp_q[$];
   int mon_e;

   multitap_delay_scale dut (
      .clk_in      (clk_in),
      .reset_in    (reset_in),
      .ready_in    (ready_in),
      .signal_in   (signal_in),
      .delay_in    (delay_in),
      .scale_in    (scale_in),
      .signal_out  (signal_out),
      .done_out    (done_out),
      .busy_out    (busy_out),
      .overrun_out (overrun_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string nm, input int act, input int expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
      end
   endtask

   // Scoreboard: every done_out pops one expected result.
   always @(negedge clk_in) begin
      if (done_out) begin
         if (exp_q.size() == 0) chk("unexpected done_out", 1, 0);
         else begin
            mon_e = exp_q.pop_front();
            chk("signal_out", int'($signed(signal_out)), mon_e);
         end
      end
   end

   task automatic wait_done();
      bit got = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk_in);
         if (done_out) begin got = 1'b1; break; end
      end
      if (!got) chk("done_out timeout", 0, 1);
   endtask

   task automatic send(input int s, input int expv);
      exp_q.push_back(expv);
      @(negedge clk_in);
      signal_in = DW'(s);
      ready_in  = 1'b1;
      @(negedge clk_in);
      ready_in  = 1'b0;
      wait_done();
   endtask

   task automatic do_reset();
      @(negedge clk_in);
      reset_in = 1'b1;
      @(negedge clk_in);
      chk("reset signal_out", int'(signal_out), 0);
      chk("reset done_out", int'(done_out), 0);
      chk("reset busy_out", int'(busy_out), 0);
      chk("reset overrun_out", int'(overrun_out), 0);
      reset_in = 1'b0;
   endtask

   typedef struct {
      bit            rst;
      int            sig;
      logic [31:0]   dly;
      logic [31:0]   scl;
      int            expv;
   } vec_t;

   vec_t vt[6];

   initial begin
      reset_in  = 1'b1;
      ready_in  = 1'b0;
      signal_in = '0;
      delay_in  = '0;
      scale_in  = '0;

`ifdef MULTITAP_DELAY_SCALE_ROUND_EN
      vt[0] = '{1'b1, 3,      32'h0, 32'h0000_0040, 2};
      vt[1] = '{1'b1, -3,     32'h0, 32'h0000_0040, -1};
`else
      vt[0] = '{1'b1, 3,      32'h0, 32'h0000_0040, 1};
      vt[1] = '{1'b1, -3,     32'h0, 32'h0000_0040, -2};
`endif
      vt[2] = '{1'b1, -32768, 32'h0, 32'h0000_8080, 32767};
      vt[3] = '{1'b1, 32767,  32'h0, 32'h0000_7F7F, 32767};
      vt[4] = '{1'b1, -32768, 32'h0, 32'h0000_7F7F, -32768};
      vt[5] = '{1'b1, 1000,   32'h0, 32'h1010_1010, 500};

      repeat (2) @(negedge clk_in);

      // Single-sample vectors
      foreach (vt[i]) begin
         if (vt[i].rst) do_reset();
         delay_in = vt[i].dly;
         scale_in = vt[i].scl;
         send(vt[i].sig, vt[i].expv);
      end

      // Impulse: tap0 delay 10, gain 0.5
      do_reset();
      delay_in = {8'd0, 8'd0, 8'd0, 8'd10};
      scale_in = {8'h00, 8'h00, 8'h00, 8'h40};
      for (int n = 0; n < 15; n++) send(n == 0 ? 1000 : 0, n == 10 ? 500 : 0);

      // Fill gating: delay 5, constant 128
      do_reset();
      delay_in = {8'd0, 8'd0, 8'd0, 8'd5};
      scale_in = {8'h00, 8'h00, 8'h00, 8'h7F};
      for (int n = 0; n < 12; n++) send(128, n < 5 ? 0 : 127);

      // Wrap-around: ramp through two pointer wraps
      do_reset();
      delay_in = {8'd0, 8'd0, 8'd0, 8'd255};
      scale_in = {8'h00, 8'h00, 8'h00, 8'h40};
      for (int n = 0; n < 600; n++) begin
`ifdef MULTITAP_DELAY_SCALE_ROUND_EN
         send(n, n >= 255 ? (n - 255 + 1) >> 1 : 0);
`else
         send(n, n >= 255 ? (n - 255) >> 1 : 0);
`endif
      end

      // Overrun and latency; tap0 delay 0, tap1 delay 1, both gain 0.5
      do_reset();
      delay_in = {8'd0, 8'd0, 8'd1, 8'd0};
      scale_in = {8'h00, 8'h00, 8'h40, 8'h40};
      exp_q.push_back(100);
      @(negedge clk_in); signal_in = 16'd200;  ready_in = 1'b1;   // edge E0
      @(negedge clk_in); ready_in = 1'b0;
      chk("busy after accept", int'(busy_out), 1);
      @(negedge clk_in); signal_in = 16'd1000; ready_in = 1'b1;   // edge E0+2
      @(negedge clk_in); ready_in = 1'b0;
      chk("overrun pulse", int'(overrun_out), 1);
      for (int k = 4; k <= 6; k++) begin
         @(negedge clk_in);
         chk("overrun cleared", int'(overrun_out), 0);
         chk("done early", int'(done_out), 0);
      end
      @(negedge clk_in);                                          // after E0+6
      chk("done latency", int'(done_out), 1);
      chk("busy in done cycle", int'(busy_out), 1);
      // ready on the edge where done drops must be accepted
      exp_q.push_back(300);
      signal_in = 16'd400; ready_in = 1'b1;
      @(negedge clk_in); ready_in = 1'b0;
      chk("no overrun on back-to-back", int'(overrun_out), 0);
      chk("busy after back-to-back", int'(busy_out), 1);
      wait_done();

      // Mid-operation reset
      do_reset();
      send(100, 50);
      send(200, 150);
      @(negedge clk_in); signal_in = 16'd999; ready_in = 1'b1;    // E0
      @(negedge clk_in); ready_in = 1'b0;
      @(negedge clk_in); reset_in = 1'b1;
      #1;
      chk("midrst signal_out", int'(signal_out), 0);
      chk("midrst busy_out", int'(busy_out), 0);
      chk("midrst done_out", int'(done_out), 0);
      chk("midrst overrun_out", int'(overrun_out), 0);
      repeat (3) @(negedge clk_in);
      reset_in = 1'b0;
      repeat (8) @(negedge clk_in);
      send(600, 300);   // tap1 gated: first sample after reset
      send(800, 700);

      repeat (4) @(negedge clk_in);
      chk("scoreboard drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
